// File: rtl/fpmac_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpmac_seq
// Purpose  : Sequential dot-product controller that streams operand pairs
//            through an external combinational FP MAC and folds the result
//            into an accumulator. Optional macro: FPMAC_SEQ_EXC_FLAG_EN adds
//            a sticky exponent-all-ones flag output (exc).
// Revision : 1.0 - initial release
// ============================================================================
module fpmac_seq #(
  parameter int BIT_WIDTH  = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [BIT_WIDTH-1:0] init_c,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic [BIT_WIDTH-1:0] mac_a,
  output logic [BIT_WIDTH-1:0] mac_b,
  output logic [BIT_WIDTH-1:0] mac_c,
  input  logic [BIT_WIDTH-1:0] mac_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
`ifdef FPMAC_SEQ_EXC_FLAG_EN
  output logic                 exc,
`endif
  output logic                 busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [BIT_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 take_start;
  logic                 beat;

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    take_start = 1'b0;
    beat       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nx   = (len != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        beat     = in_valid;
        // cnt+1 is compared at LEN_WIDTH bits, so len=all-ones ends at cnt=max-1
        if (in_valid && ((cnt + LEN_ONE) == len_q)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      if (take_start) begin
        len_q <= len;
        acc   <= init_c;
        cnt   <= '0;
      end else if (beat) begin
        acc <= mac_res;
        cnt <= cnt + LEN_ONE;
      end
    end
  end

  assign mac_a    = in_a;
  assign mac_b    = in_b;
  assign mac_c    = acc;
  assign out_data = acc;
  assign busy     = (state != IDLE);

`ifdef FPMAC_SEQ_EXC_FLAG_EN
  // A new job restarts the flag from its own seed rather than clearing to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc <= 1'b0;
    end else if (take_start) begin
      exc <= &init_c[MANT_WIDTH +: EXP_WIDTH];
    end else if (beat) begin
      exc <= exc | (&in_a[MANT_WIDTH +: EXP_WIDTH]) | (&in_b[MANT_WIDTH +: EXP_WIDTH]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpmac_seq.sv
`default_nettype none
// Testbench for fpmac_seq: directed vector table, hand sequences for reset,
// DONE back-pressure and long jobs, plus randomized jobs against a real-valued model.
module tb_fpmac_seq;
  localparam int BW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [LW-1:0] len;
  logic [BW-1:0] init_c, in_a, in_b, mac_a, mac_b, mac_c, mac_res, out_data;
  logic          in_ready, out_valid, busy;
`ifdef FPMAC_SEQ_EXC_FLAG_EN
  logic          exc;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] va[256];
  logic [31:0] vb[256];

  always #5 clk = ~clk;

  fpmac_seq #(.BIT_WIDTH(BW), .EXP_WIDTH(8), .MANT_WIDTH(23), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .init_c(init_c),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_res(mac_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef FPMAC_SEQ_EXC_FLAG_EN
    .exc(exc),
`endif
    .busy(busy)
  );

  // Single-precision <-> real via double re-biasing (exact for the small integers used)
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return r2sp(sp2r(a) * sp2r(b) + sp2r(c));
  endfunction

  always_comb mac_res = mac_fn(mac_a, mac_b, mac_c);

  function automatic logic [31:0] ref_dot(input int n, input logic [31:0] init);
    real r;
    r = sp2r(init);
    for (int i = 0; i < n; i++) r = r + sp2r(va[i]) * sp2r(vb[i]);
    return r2sp(r);
  endfunction

  function automatic logic [31:0] rnd_small();
    real r;
    r = real'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) r = -r;
    return r2sp(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // gap < 0 selects a random 0..2 cycle in_valid gap before each beat
  task automatic run_job(input string tag, input int n, input logic [31:0] init,
                         input int gap, input logic [31:0] expv);
    int g;
    start = 1'b1; len = LW'(n); init_c = init;
    step();
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (n == 0) begin
      chk({tag, " in_ready len0"}, 32'(in_ready), 32'd0);
      chk({tag, " out_valid len0"}, 32'(out_valid), 32'd1);
    end else begin
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " seed"}, out_data, init);
    end
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      in_a = va[i]; in_b = vb[i];
      start = 1'($urandom_range(0, 1));
      in_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        step();
        chk({tag, " gap hold"}, mac_c, ref_dot(i, init));
        chk({tag, " gap out_valid"}, 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      start = 1'b0;
      chk({tag, " out_valid after beat"}, 32'(out_valid), (i == n - 1) ? 32'd1 : 32'd0);
    end
    chk({tag, " out_data"}, out_data, expv);
    chk({tag, " in_ready done"}, 32'(in_ready), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      step();
      chk({tag, " hold out_data"}, out_data, expv);
    end
    handshake(tag);
  endtask

  typedef struct {
    int          n;
    logic [31:0] init;
    logic [31:0] a0, b0, a1, b1;
    int          gap;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] init;
    tbl[0] = '{2, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 0, 32'h40400000};
    tbl[1] = '{1, 32'h3F000000, 32'h3F800000, 32'h40000000, 32'h0, 32'h0, 3, 32'h40200000};
    tbl[2] = '{0, 32'h40400000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h40400000};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; init_c = '0; in_a = '0; in_b = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);

    foreach (tbl[t]) begin
      va[0] = tbl[t].a0; vb[0] = tbl[t].b0; va[1] = tbl[t].a1; vb[1] = tbl[t].b1;
      run_job($sformatf("vec%0d", t), tbl[t].n, tbl[t].init, tbl[t].gap, tbl[t].expv);
    end

    // Reset mid-accumulation after one of three beats
    for (int i = 0; i < 3; i++) begin va[i] = 32'h3F800000; vb[i] = 32'h40000000; end
    start = 1'b1; len = 8'd3; init_c = 32'h3F800000;
    step();
    start = 1'b0; in_a = va[0]; in_b = vb[0]; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("abort partial acc", out_data, 32'h40400000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort acc", out_data, 32'd0);
    repeat (3) begin
      step();
      chk("abort no out_valid", 32'(out_valid), 32'd0);
    end
    run_job("post-reset", 3, 32'h3F800000, 0, 32'h40E00000);

    // DONE back-pressure: start ignored, simultaneous start+out_ready not taken
    va[0] = 32'h3F800000; vb[0] = 32'h40000000;
    start = 1'b1; len = 8'd1; init_c = 32'h0;
    step();
    start = 1'b0; in_a = va[0]; in_b = vb[0]; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); len = 8'd0; init_c = 32'h12345678;
      step();
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_data", out_data, 32'h40000000);
    end
    start = 1'b1; out_ready = 1'b1; len = 8'd0; init_c = 32'h40400000;
    step();
    out_ready = 1'b0;
    chk("bp handshake no restart", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk("bp restart busy", 32'(busy), 32'd1);
    chk("bp restart out_valid", 32'(out_valid), 32'd1);
    chk("bp restart out_data", out_data, 32'h40400000);
    handshake("bp");

    // Maximum-length job
    for (int i = 0; i < 255; i++) begin va[i] = rnd_small(); vb[i] = rnd_small(); end
    run_job("maxlen", 255, 32'h3F800000, -1, ref_dot(255, 32'h3F800000));

    // Randomized jobs against the real-valued model
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(0, 12);
      init = rnd_small();
      for (int i = 0; i < n; i++) begin va[i] = rnd_small(); vb[i] = rnd_small(); end
      run_job($sformatf("rnd%0d", j), n, init, -1, ref_dot(n, init));
    end

`ifdef FPMAC_SEQ_EXC_FLAG_EN
    start = 1'b1; len = 8'd1; init_c = 32'h0;
    step();
    start = 1'b0;
    chk("exc cleared at start", 32'(exc), 32'd0);
    in_a = 32'h7F800000; in_b = 32'h3F800000; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_a = 32'h0;
    chk("exc set", 32'(exc), 32'd1);
    handshake("exc");
    chk("exc sticky idle", 32'(exc), 32'd1);
    start = 1'b1; len = 8'd0; init_c = 32'h3F800000;
    step();
    start = 1'b0;
    chk("exc cleared next start", 32'(exc), 32'd0);
    handshake("exc2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fpmac_seq.md
FPMAC_SEQ -- requirements
Module: fpmac_seq

Interface
REQ-001 SHALL provide parameter BIT_WIDTH, default 32: FP word width.
REQ-002 SHALL provide parameter EXP_WIDTH, default 8: exponent field width.
REQ-003 SHALL provide parameter MANT_WIDTH, default 23: mantissa field width.
REQ-004 SHALL provide parameter LEN_WIDTH, default 8: vector-length counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: begin a dot-product job; sampled only in IDLE.
REQ-008 SHALL have port len, input, LEN_WIDTH: number of (a,b) pairs in the job, latched on start.
REQ-009 SHALL have port init_c, input, BIT_WIDTH: accumulator seed, latched on start.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, BIT_WIDTH), in_b (input, BIT_WIDTH): operand-pair stream.
REQ-011 SHALL have ports mac_a, mac_b, mac_c (output, BIT_WIDTH each): drive the combinational MAC inputs in_a, in_b, in_c.
REQ-012 SHALL have port mac_res, input, BIT_WIDTH: combinational MAC result (in_a*in_b+in_c).
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, BIT_WIDTH): result stream.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE.
REQ-016 IDLE: start=1 latches len into len_q, init_c into acc, clears cnt; next state ACC if len!=0, else DONE.
REQ-017 ACC: in_ready=1; beat = in_valid&in_ready; on beat acc<=mac_res and cnt<=cnt+1.
REQ-018 ACC: beat with cnt==len_q-1 SHALL move to DONE in the same edge; no beat -> hold all state.
REQ-019 mac_a=in_a, mac_b=in_b, mac_c=acc, combinationally, in every state.
REQ-020 DONE: out_valid=1, out_data=acc; on out_ready=1 next state IDLE; else hold out_data stable.
REQ-021 in_ready SHALL be 0 in IDLE and DONE; out_valid SHALL be 0 in IDLE and ACC.
REQ-022 Latency: out_valid asserts the cycle after the final accepted beat; len=0 job asserts out_valid the cycle after start, out_data=init_c.
REQ-023 start while not IDLE SHALL be ignored; start and out_ready handshake in the same DONE cycle SHALL NOT start a new job (start seen next cycle in IDLE).
REQ-024 cnt SHALL be LEN_WIDTH bits; len=2^LEN_WIDTH-1 SHALL complete without wrap error.
REQ-025 out_data outside DONE SHALL equal acc (no X).

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, acc=0, cnt=0, len_q=0, in_ready=0, out_valid=0, busy=0, from any state including mid-job.
REQ-027 A job aborted by reset SHALL produce no out_valid; the first start after rst deasserts SHALL run normally.

Configuration
REQ-028 Macro FPMAC_SEQ_EXC_FLAG_EN defined: add output exc (1 bit), sticky, set when any accepted in_a, in_b, or latched init_c has all-ones exponent, cleared on accepted start and on rst.
REQ-029 Macro FPMAC_SEQ_EXC_FLAG_EN undefined: exc port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset mid-ACC after 1 of 3 beats -> next cycle busy=0, in_ready=0, out_valid=0, acc=0.
REQ-031 start, len=2, init_c=0x00000000, beats (0x3F800000,0x40000000),(0x3F800000,0x3F800000) -> out_data=0x40400000 (3.0) with out_valid the cycle after beat 2.
REQ-032 start, len=1, init_c=0x3F000000, beat (0x3F800000,0x40000000) with in_valid gaps of 3 cycles -> out_data=0x40200000 (2.5), acc unchanged during gaps.
REQ-033 start, len=0, init_c=0x40400000 -> out_valid next cycle, out_data=0x40400000, in_ready never asserted.
REQ-034 DONE with out_ready=0 for 5 cycles, start pulsed -> out_data stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-035 FPMAC_SEQ_EXC_FLAG_EN defined, beat in_a=0x7F800000 -> exc=1 until next accepted start; undefined build -> compiles without exc port.
